regfile_sequencer: RTL and testbench

Multi-cycle operation sequencer that drives the 16 x 8-bit signed register file as its initiator. Accepts one register-to-register operation per handshake, reads both source operands through the file's two read ports, computes a signed 8-bit ALU result, and writes it back through the file's write port. Sits between the instruction source (test sequencer or future decode stage) and the register file in the simple computer datapath.

---
 rtl/regfile_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
//
// Multi-cycle sequencer that acts as the initiator for a 16 x 8-bit signed
// register file. One register-to-register operation is accepted per
// handshake and walks IDLE -> READ -> EXEC -> WRITE -> IDLE:
//   READ  : source operands are addressed on RA1/RA2 and captured into A/B
//   EXEC  : signed 8-bit ALU result and flags are computed and registered
//   WRITE : result is presented on WA/data_in with write_enable (not for NOP)
//
// Optional feature macro: SAT_ARITH_EN
//   defined     -> ADD/SUB saturate to +127 / -128 on overflow
//   not defined -> ADD/SUB wrap modulo 256
//   ovf is produced identically in both builds.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   op_valid      in   operation request
//   op_ready      out  high only in IDLE
//   opcode        in   3-bit op: ADD SUB AND OR XOR LDI MOV NOP
//   rd, rs1, rs2  in   destination / source register addresses
//   imm           in   signed immediate for LDI
//   RA1, RA2      out  register file read addresses
//   data_out1/2   in   register file read data (combinational on RA1/RA2)
//   WA            out  register file write address
//   data_in       out  register file write data
//   write_enable  out  register file write strobe (WRITE state, not NOP)
//   done          out  one-cycle pulse in the WRITE state
//   result        out  last computed result, held until the next EXEC
//   ovf, zero     out  flags of the last result, held with result
// -----------------------------------------------------------------------------
module regfile_sequencer #(
    parameter int NREGS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [2:0]                  opcode,
    input  logic [$clog2(NREGS)-1:0]    rd,
    input  logic [$clog2(NREGS)-1:0]    rs1,
    input  logic [$clog2(NREGS)-1:0]    rs2,
    input  logic signed [7:0]           imm,
    output logic [$clog2(NREGS)-1:0]    RA1,
    output logic [$clog2(NREGS)-1:0]    RA2,
    input  logic signed [7:0]           data_out1,
    input  logic signed [7:0]           data_out2,
    output logic [$clog2(NREGS)-1:0]    WA,
    output logic signed [7:0]           data_in,
    output logic                        write_enable,
    output logic                        done,
    output logic signed [7:0]           result,
    output logic                        ovf,
    output logic                        zero
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LDI = 3'b101,
        OP_MOV = 3'b110,
        OP_NOP = 3'b111
    } opcode_t;

    state_t             state, state_nxt;
    opcode_t            opc_q;
    logic [AW-1:0]      rd_q;
    logic signed [7:0]  imm_q;
    logic signed [7:0]  a_q, b_q;

    logic               accept;
    logic signed [7:0]  alu_res;
    logic               alu_ovf;
    logic signed [8:0]  sum9, diff9;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Next state and state-decoded outputs. write_enable/done/op_ready are
    // decoded from state so an asynchronous reset drops them immediately.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        op_ready     = 1'b0;
        write_enable = 1'b0;
        done         = 1'b0;
        unique case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_nxt = S_READ;
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: begin
                done         = 1'b1;
                write_enable = (opc_q != OP_NOP);
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = (state == S_IDLE) && op_valid;

    // -------------------------------------------------------------------------
    // ALU: 9-bit sign-extended sums give the true result; overflow is when
    // the 9-bit sign disagrees with bit 7 of the truncated result.
    // -------------------------------------------------------------------------
    assign sum9  = {a_q[7], a_q} + {b_q[7], b_q};
    assign diff9 = {a_q[7], a_q} - {b_q[7], b_q};

    always_comb begin
        alu_res = result;
        alu_ovf = 1'b0;
        unique case (opc_q)
            OP_ADD: begin
                alu_ovf = (sum9[8] != sum9[7]);
`ifdef SAT_ARITH_EN
                alu_res = alu_ovf ? (sum9[8] ? 8'sh80 : 8'sh7f) : sum9[7:0];
`else
                alu_res = sum9[7:0];
`endif
            end
            OP_SUB: begin
                alu_ovf = (diff9[8] != diff9[7]);
`ifdef SAT_ARITH_EN
                alu_res = alu_ovf ? (diff9[8] ? 8'sh80 : 8'sh7f) : diff9[7:0];
`else
                alu_res = diff9[7:0];
`endif
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_LDI:  alu_res = imm_q;
            OP_MOV:  alu_res = a_q;
            OP_NOP:  alu_res = result;
            default: alu_res = result;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers. Read/write addresses and write data hold their
    // values outside the states that update them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opc_q   <= OP_NOP;
            rd_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            RA1     <= '0;
            RA2     <= '0;
            WA      <= '0;
            data_in <= '0;
            result  <= '0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            if (accept) begin
                opc_q <= opcode_t'(opcode);
                rd_q  <= rd;
                imm_q <= imm;
                // Source addresses are latched straight onto the read ports
                // so they are stable for the whole READ cycle.
                RA1   <= rs1;
                RA2   <= rs2;
            end
            if (state == S_READ) begin
                a_q <= data_out1;
                b_q <= data_out2;
            end
            if (state == S_EXEC) begin
                result  <= alu_res;
                ovf     <= alu_ovf;
                zero    <= (alu_res == 8'sd0);
                WA      <= rd_q;
                data_in <= alu_res;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_sequencer
//
// Bench for regfile_sequencer. Provides a behavioural 16 x 8 register file,
// pushes the expected outcome of each accepted operation into a scoreboard
// queue and compares it when done pulses. Honours SAT_ARITH_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_sequencer;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010,
                           OR_ = 3'b011, XOR_ = 3'b100, LDI = 3'b101,
                           MOV = 3'b110, NOP = 3'b111;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [2:0]        opcode = 3'b111;
    logic [3:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic signed [7:0] imm = '0;
    logic [3:0]        RA1, RA2, WA;
    logic signed [7:0] data_out1, data_out2, data_in;
    logic              write_enable, done, ovf, zero;
    logic signed [7:0] result;

    regfile_sequencer #(.NREGS(16)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .RA1(RA1), .RA2(RA2), .data_out1(data_out1), .data_out2(data_out2),
        .WA(WA), .data_in(data_in), .write_enable(write_enable),
        .done(done), .result(result), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // Behavioural register file (not reset, like the real array).
    logic signed [7:0] rf [16];
    initial for (int i = 0; i < 16; i++) rf[i] = '0;
    assign data_out1 = rf[RA1];
    assign data_out2 = rf[RA2];
    always @(posedge clk) if (write_enable) rf[WA] <= data_in;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]        rd;
        logic signed [7:0] res;
        logic              ovf;
        logic              zero;
        logic              we;
        int                hs;
    } sb_t;

    sb_t               sb[$];
    logic signed [7:0] mrf [16];
    logic signed [7:0] last_res = '0;
    int                last_hs  = 0;
    initial for (int i = 0; i < 16; i++) mrf[i] = '0;

    // Reference ALU using integer arithmetic.
    function automatic sb_t model(input logic [2:0] op, input logic signed [7:0] a,
                                  input logic signed [7:0] b, input logic signed [7:0] im);
        sb_t e;
        int  t;
        e.ovf = 1'b0;
        e.we  = (op != NOP);
        e.rd  = '0;
        e.hs  = 0;
        case (op)
            ADD, SUB: begin
                t = (op == ADD) ? (int'(a) + int'(b)) : (int'(a) - int'(b));
                e.ovf = (t > 127) || (t < -128);
`ifdef SAT_ARITH_EN
                if (t > 127)       e.res = 8'sd127;
                else if (t < -128) e.res = -8'sd128;
                else               e.res = t[7:0];
`else
                e.res = t[7:0];
`endif
            end
            AND_:    e.res = a & b;
            OR_:     e.res = a | b;
            XOR_:    e.res = a ^ b;
            LDI:     e.res = im;
            MOV:     e.res = a;
            default: e.res = last_res;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Drive one request and wait for its handshake; op_valid stays high.
    task automatic send_op(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1,
                           input logic [3:0] s2, input logic signed [7:0] im);
        sb_t e;
        int  budget;
        @(negedge clk);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im;
        op_valid = 1'b1;
        budget = 0;
        while (!op_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!op_ready) check("handshake_timeout", 0, 1);
        e    = model(op, mrf[s1], mrf[s2], im);
        e.rd = d;
        e.hs = cyc;
        last_hs = cyc;
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((sb.size() != 0 || !op_ready) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("latency", cyc - e.hs, 3);
                check("result", result, e.res);
                check("ovf", ovf, e.ovf);
                check("zero", zero, e.zero);
                check("write_enable", write_enable, e.we);
                if (e.we) begin
                    check("WA", WA, e.rd);
                    check("data_in", data_in, e.res);
                    mrf[e.rd] = e.res;
                end
                last_res = e.res;
            end
        end
    end

    int hs_a;
    logic signed [7:0] exp_ovf_res;

    initial begin
`ifdef SAT_ARITH_EN
        exp_ovf_res = 8'sd127;
`else
        exp_ovf_res = -8'sd106;
`endif
        // Reset state
        #12;
        check("rst_op_ready", op_ready, 1);
        check("rst_we", write_enable, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        check("rst_zero", zero, 0);
        check("rst_RA1", RA1, 0);
        check("rst_WA", WA, 0);
        @(negedge clk);
        reset = 1'b0;

        // LDI r3=-6, LDI r5=10
        send_op(LDI, 4'd3, 4'd0, 4'd0, -8'sd6);  op_valid = 1'b0; wait_drain();
        send_op(LDI, 4'd5, 4'd0, 4'd0, 8'sd10);  op_valid = 1'b0; wait_drain();
        check("rf3", rf[3], -6);
        check("rf5", rf[5], 10);

        // ADD r7=r3+r5, SUB r8=r3-r3
        send_op(ADD, 4'd7, 4'd3, 4'd5, 8'sd0);   op_valid = 1'b0; wait_drain();
        check("rf7", rf[7], 4);
        send_op(SUB, 4'd8, 4'd3, 4'd3, 8'sd0);   op_valid = 1'b0; wait_drain();
        check("rf8", rf[8], 0);
        check("sub_zero", zero, 1);

        // Overflow: 100 + 50
        send_op(LDI, 4'd1, 4'd0, 4'd0, 8'sd100); op_valid = 1'b0; wait_drain();
        send_op(LDI, 4'd2, 4'd0, 4'd0, 8'sd50);  op_valid = 1'b0; wait_drain();
        send_op(ADD, 4'd4, 4'd1, 4'd2, 8'sd0);   op_valid = 1'b0; wait_drain();
        check("rf4", rf[4], exp_ovf_res);
        check("add_ovf", ovf, 1);

        // NOP with rd=3 leaves r3 untouched
        send_op(NOP, 4'd3, 4'd0, 4'd0, 8'sd77);  op_valid = 1'b0; wait_drain();
        check("nop_rf3", rf[3], -6);

        // Reset during the WRITE cycle of LDI r9=55
        send_op(LDI, 4'd9, 4'd0, 4'd0, 8'sd55);  op_valid = 1'b0;
        @(posedge clk);               // into EXEC
        @(posedge clk);               // into WRITE
        #1;
        check("pre_rst_we", write_enable, 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_we", write_enable, 0);
        check("async_done", done, 0);
        check("async_ready", op_ready, 1);
        sb.delete();
        last_res = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rf9_kept", rf[9], 0);
        check("post_rst_ready", op_ready, 1);
        check("post_rst_result", result, 0);

        // op_valid held high: MOV r6=r5 then AND r6=r6&r3
        send_op(MOV, 4'd6, 4'd5, 4'd0, 8'sd0);
        hs_a = last_hs;
        send_op(AND_, 4'd6, 4'd6, 4'd3, 8'sd0);
        check("hs_spacing", last_hs - hs_a, 4);
        op_valid = 1'b0;
        wait_drain();
        check("rf6", rf[6], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
